seq_chk_fsm: RTL and testbench
==============================

Name: seq_chk_fsm

Overview:
- Serial bit-pattern detector built as a Moore FSM.
- Samples one bit of `din` on every rising clock edge and pulses `success_flag` for one cycle when the last SEQ_LEN received bits equal SEQ_PATTERN.
- Used as a stand-alone checker on a serial data line. Downstream logic samples `success_flag` as a single-cycle event.

Parameters:
- SEQ_LEN, 5, pattern length in bits; legal range 2..16.
- SEQ_PATTERN, 5'b10010, SEQ_LEN-bit target pattern. The MSB is the first bit received on `din`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data; one bit sampled per rising edge of clk.
- success_flag  output  1  high for exactly one clk cycle per detected pattern.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high: while rst=1 at a rising edge, state <= IDLE (0 bits matched) and success_flag <= 0.
  - `din` is ignored on any edge where rst=1.
- States:
  - MATCHED_0 .. MATCHED_{SEQ_LEN-1}, where MATCHED_k means the last k received bits equal the first k pattern bits, and k is the longest such prefix.
  - MATCHED_0 is IDLE.
  - Plus FOUND, entered on the edge that samples the final pattern bit.
  - State encoding: binary counter of width clog2(SEQ_LEN+1).
- Transitions from MATCHED_k, k < SEQ_LEN-1:
  - If din equals pattern bit k (counted from the MSB), go to MATCHED_{k+1}.
  - Otherwise go to MATCHED_j, where j is the length of the longest proper suffix of (received prefix + din) that is also a pattern prefix (KMP failure rule). j may be 0.
  - All fallback targets are elaboration-time constants derived from SEQ_PATTERN. No runtime search.
- Transitions from MATCHED_{SEQ_LEN-1}:
  - Matching din goes to FOUND.
  - Otherwise apply the fallback rule above.
- Transitions from FOUND: the bit sampled on this edge is processed as described under Optional Feature.
- Output:
  - success_flag = 1 exactly while state == FOUND. It is decoded from the state register only, so it is glitch-free with no combinational path from din.
  - Latency: success_flag rises on the same rising edge that samples the final pattern bit and stays high for one full cycle.
  - Back-to-back FOUND (a pattern ending on consecutive edges) is only possible for degenerate patterns such as all-ones. It must then produce a continuous high, one cycle per match.
- Reset mid-sequence discards all partial-match history; the first post-reset bit is treated as bit 0.
- No X propagation: an X or Z on din is not required to be handled.
- Outputs are defined from the first reset edge onward.

Optional Feature:
- Macro: SEQ_CHK_OVERLAP_EN.
- Defined: overlapping detection. From FOUND, the next bit is processed as if the state were MATCHED_p, where p is the length of the longest proper suffix of SEQ_PATTERN that is also a pattern prefix.
  - Default pattern 10010 gives p = 2, so FOUND plus din=0 goes to MATCHED_3.
- Undefined: non-overlapping detection. From FOUND, the next bit is processed as from IDLE, and no bits of a found pattern are reused.
- The reset and output rules are identical in both builds.

Decomposition:
- Package seq_chk_pkg:
  - default SEQ_LEN and SEQ_PATTERN constants;
  - a state-width function clog2;
  - a constant function computing the prefix/failure table for a given pattern and length.
- A separate sub-module is not needed. Next-state logic, state register and output decode all live in seq_chk_fsm.

Test Plan:
- Reset: hold rst=1 for 3 cycles with din=1 throughout; release -> success_flag=0 during reset and on the first post-reset edge.
- Basic match: din 1,0,0,1,0 -> success_flag=1 only in the cycle following the 5th sampling edge, 0 elsewhere.
- Overlap: din 1,0,0,1,0,0,1,0 -> with SEQ_CHK_OVERLAP_EN, pulses after the 5th and 8th bits; without it, a pulse after the 5th bit only.
- Fallback: din 1,0,0,0,1,0 -> no pulse. din 1,1,0,0,1,0 -> single pulse after the 6th bit, which checks the restart from MATCHED_1.
- Reset mid-sequence: din 1,0,0, then rst=1 for 1 cycle, then din 1,0 -> no pulse. Follow with 0,1,0 -> pulse after the final 0.
- Random soak: 10000 cycles of random din with random single-cycle rst pulses, compared cycle-by-cycle against a shift-register reference model. The model is mode-aware: it clears its history after a hit when SEQ_CHK_OVERLAP_EN is undefined -> zero mismatches.

Source files
------------

// File: rtl/seq_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_chk_pkg
// Description : Shared constants and elaboration-time helpers for the
//               serial pattern detector seq_chk_fsm.
//               - default pattern length and pattern value
//               - clog2 state-width function
//               - mismatch-fallback (KMP failure) table generator
//               - overlap restart length (longest proper border of pattern)
//               Pattern bit i is counted from the MSB, i.e. bit 0 is the
//               first bit seen on the serial line.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_chk_pkg;

    localparam int          c_seq_len_default     = 5;
    localparam logic [4:0]  c_seq_pattern_default = 5'b10010;
    localparam int          c_seq_len_max         = 16;

    // One fallback target per MATCHED_k state, k = 0..15; 5 bits covers 0..16.
    typedef logic [c_seq_len_max-1:0][4:0] fail_tbl_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Bit i of the pattern in arrival order.
    function automatic logic pat_bit(input logic [15:0] pat, input int len, input int i);
        return pat[len-1-i];
    endfunction

    // Pattern reversed so that index i holds the i-th received bit.
    function automatic logic [15:0] pat_in_order(input logic [15:0] pat, input int len);
        logic [15:0] res;
        res = '0;
        for (int i = 0; i < len; i++) begin
            res[i] = pat_bit(pat, len, i);
        end
        return res;
    endfunction

    // For every MATCHED_k, the state reached when din mismatches pattern bit k:
    // the longest suffix of (first k pattern bits + inverted bit k) that is
    // also a pattern prefix. Computed by brute force at elaboration time.
    function automatic fail_tbl_t seq_chk_fail_table(input logic [15:0] pat, input int len);
        fail_tbl_t   tbl;
        logic [16:0] seen;
        int          best;
        logic        ok;
        tbl = '0;
        for (int k = 0; k < len; k++) begin
            seen = '0;
            for (int m = 0; m < k; m++) begin
                seen[m] = pat_bit(pat, len, m);
            end
            seen[k] = ~pat_bit(pat, len, k);
            best = 0;
            for (int j = k; j >= 1; j--) begin
                if (best == 0) begin
                    ok = 1'b1;
                    for (int i = 0; i < j; i++) begin
                        if (seen[k+1-j+i] != pat_bit(pat, len, i)) begin
                            ok = 1'b0;
                        end
                    end
                    if (ok) begin
                        best = j;
                    end
                end
            end
            tbl[k] = 5'(best);
        end
        return tbl;
    endfunction

    // Length of the longest proper suffix of the pattern that is also a prefix.
    function automatic int seq_chk_overlap_len(input logic [15:0] pat, input int len);
        int   best;
        logic ok;
        best = 0;
        for (int j = len - 1; j >= 1; j--) begin
            if (best == 0) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    if (pat_bit(pat, len, len - j + i) != pat_bit(pat, len, i)) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return best;
    endfunction

endpackage : seq_chk_pkg
`default_nettype wire

// File: rtl/seq_chk_fsm.sv
`default_nettype none
// ============================================================================
// Module      : seq_chk_fsm
// Description : Moore-FSM serial bit-pattern detector. One bit of din is
//               sampled per rising clk edge; success_flag is high for one
//               cycle whenever the last SEQ_LEN bits equal SEQ_PATTERN
//               (MSB received first).
// Ports       : clk          - system clock, rising edge
//               rst          - synchronous active-high reset
//               din          - serial data input
//               success_flag - one-cycle detection pulse, decoded from state
// Build macro : SEQ_CHK_OVERLAP_EN - when defined, a found pattern's border is
//               reused for the next match (overlapping detection); otherwise
//               detection restarts from IDLE after each hit.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_chk_fsm
    import seq_chk_pkg::*;
#(
    parameter int                 SEQ_LEN     = c_seq_len_default,
    parameter logic [SEQ_LEN-1:0] SEQ_PATTERN = c_seq_pattern_default
)(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic success_flag
);

    localparam int W = clog2(SEQ_LEN + 1);

    // State encoding: binary count of matched prefix bits; SEQ_LEN means FOUND.
    localparam logic [W-1:0] c_st_idle  = '0;
    localparam logic [W-1:0] c_st_found = W'(SEQ_LEN);

    localparam logic [15:0] c_pat_order = pat_in_order(16'(SEQ_PATTERN), SEQ_LEN);
    localparam fail_tbl_t   c_fail      = seq_chk_fail_table(16'(SEQ_PATTERN), SEQ_LEN);

`ifdef SEQ_CHK_OVERLAP_EN
    localparam logic [W-1:0] c_resume = W'(seq_chk_overlap_len(16'(SEQ_PATTERN), SEQ_LEN));
`else
    localparam logic [W-1:0] c_resume = c_st_idle;
`endif

    logic [W-1:0] r_state;
    logic [W-1:0] w_state_next;
    logic [W-1:0] w_cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FOUND behaves like the restart state for the bit sampled on this edge,
    // so a single matched/mismatched decision covers every state.
    always_comb begin
        w_cur        = r_state;
        w_state_next = c_st_idle;
        if (r_state == c_st_found) begin
            w_cur = c_resume;
        end
        if (din == c_pat_order[w_cur]) begin
            w_state_next = w_cur + W'(1);
        end else begin
            w_state_next = W'(c_fail[w_cur]);
        end
    end

    assign success_flag = (r_state == c_st_found);

endmodule : seq_chk_fsm
`default_nettype wire

// File: tb/tb_seq_chk_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_chk_fsm
// Description : Self-checking bench for seq_chk_fsm. Directed vector table
//               with hand-derived expectations, then a random soak checked
//               against a bit-history reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_chk_fsm;

    localparam int         LEN = 5;
    localparam logic [4:0] PAT = 5'b10010;

`ifdef SEQ_CHK_OVERLAP_EN
    localparam bit c_overlap = 1'b1;
`else
    localparam bit c_overlap = 1'b0;
`endif

    typedef struct {
        bit rst;
        bit din;
        bit exp;
    } vec_t;

    logic clk;
    logic rst;
    logic din;
    logic success_flag;

    int n_compared;
    int n_failed;

    seq_chk_fsm #(
        .SEQ_LEN     (LEN),
        .SEQ_PATTERN (PAT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .success_flag (success_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input bit r, input bit d, input bit exp, input string name, input int idx);
        @(negedge clk);
        rst = r;
        din = d;
        @(posedge clk);
        #1;
        n_compared++;
        if (success_flag !== exp) begin
            n_failed++;
            $display("FAIL %s step %0d: success_flag=%0b expected=%0b", name, idx, success_flag, exp);
        end
    endtask

    vec_t vecs[$];

    task automatic add_reset(input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{1'b1, 1'b1, 1'b0});
    endtask

    task automatic add_bits(input string bits, input string exps);
        for (int i = 0; i < bits.len(); i++) begin
            vecs.push_back('{1'b0, bits[i] == "1", exps[i] == "1"});
        end
    endtask

    // Reference model: history of bits since the last reset (and, without
    // overlap, since the last hit); a hit is the last LEN bits equal PAT.
    logic [15:0] m_hist;
    int          m_cnt;

    function automatic bit model_step(input bit r, input bit d);
        bit hit;
        if (r) begin
            m_cnt  = 0;
            m_hist = '0;
            return 1'b0;
        end
        m_hist = {m_hist[14:0], d};
        m_cnt++;
        hit = (m_cnt >= LEN) && (m_hist[LEN-1:0] == PAT);
        if (hit && !c_overlap) m_cnt = 0;
        return hit;
    endfunction

    initial begin
        n_compared = 0;
        n_failed   = 0;
        rst = 1'b1;
        din = 1'b1;

        // Reset held 3 cycles with din=1, then basic match.
        add_reset(3);
        add_bits("10010", "00001");
        // Overlap: second pulse only when borders are reused.
        add_reset(1);
        if (c_overlap) add_bits("10010010", "00001001");
        else           add_bits("10010010", "00001000");
        // Fallbacks.
        add_reset(1);
        add_bits("100010", "000000");
        add_reset(1);
        add_bits("110010", "000001");
        // Reset mid-sequence discards history.
        add_reset(1);
        add_bits("100", "000");
        add_reset(1);
        add_bits("10", "00");
        add_bits("010", "001");
        // Partial prefix then trailing ones.
        add_reset(1);
        add_bits("1001110010", "0000000001");

        foreach (vecs[i]) apply(vecs[i].rst, vecs[i].din, vecs[i].exp, "directed", i);

        // Random soak with occasional single-cycle resets.
        apply(1'b1, 1'b0, 1'b0, "soak_reset", 0);
        void'(model_step(1'b1, 1'b0));
        for (int i = 0; i < 10000; i++) begin
            bit r;
            bit d;
            bit e;
            r = ($urandom_range(63) == 0);
            d = $urandom_range(1) == 1;
            e = model_step(r, d);
            apply(r, d, e, "soak", i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule : tb_seq_chk_fsm
`default_nettype wire
